// File: rtl/mem_line_sequencer_if.sv
// Memory-side bus of mem_line_sequencer: level read/write requests with an
// address/write-data pair, answered by a one-cycle response pulse.
// master = sequencer side, slave = main memory model side.
interface mem_line_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read_req;
    logic              mem_write_req;
    logic              mem_res;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_read_req, mem_write_req,
        input  mem_res, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read_req, mem_write_req,
        output mem_res, mem_rdata
    );
endinterface

// File: rtl/mem_line_sequencer.sv
// mem_line_sequencer: shares one main-memory port between the I-side and
// D-side L2 refill/writeback paths. Grants round-robin, then walks a full
// line as LINE_WORDS single-word beats. Between beats the request is dropped
// for one cycle so the memory sees a fresh rising edge per beat.
// Optional feature: define MEM_SEQ_TIMEOUT_EN to add a per-beat watchdog that
// aborts the line after TIMEOUT_CYCLES waiting cycles and pulses err.
module mem_line_sequencer #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          mem_clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          i_rvalid,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic                          d_rvalid,
    output logic                          d_done,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(LINE_WORDS)-1:0] beat,
    output logic                          err,
    mem_line_sequencer_if.master          mem
);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFS    = BEAT_W + 2;
    localparam int LINE_W = ADDR_W - OFS;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    state_t            state;
    side_t             side;
    side_t             last_grant;
    logic              is_write;
    logic [LINE_W-1:0] line_q;

    logic              grant_any;
    logic              grant_d;
    logic [LINE_W-1:0] sel_line;

    // Offset bits of the client addresses are don't-care by definition.
    logic unused_ok;
    assign unused_ok = &{1'b0, i_addr[OFS-1:0], d_addr[OFS-1:0], (TIMEOUT_CYCLES > 0)};

`ifdef MEM_SEQ_TIMEOUT_EN
    logic [15:0] wdog;
`else
    assign err = 1'b0;
`endif

    // Round-robin pick: a tie goes to the side that was not served last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_any = i_req | d_req;
        grant_d   = d_req && (!i_req || (last_grant == SIDE_I));
        sel_line  = grant_d ? d_addr[ADDR_W-1:OFS] : i_addr[ADDR_W-1:OFS];
    end

    // Line sequencing FSM with all outputs registered.
    always_ff @(posedge mem_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (rst) begin
            state             <= S_IDLE;
            side              <= SIDE_I;
            last_grant        <= SIDE_I;
            is_write          <= 1'b0;
            line_q            <= '0;
            beat              <= '0;
            rdata             <= '0;
            i_rvalid          <= 1'b0;
            i_done            <= 1'b0;
            d_rvalid          <= 1'b0;
            d_done            <= 1'b0;
            mem.mem_addr      <= '0;
            mem.mem_wdata     <= '0;
            mem.mem_read_req  <= 1'b0;
            mem.mem_write_req <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
            wdog              <= '0;
            err               <= 1'b0;
`endif
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
            err      <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    beat <= '0;
                    if (grant_any) begin
                        side              <= grant_d ? SIDE_D : SIDE_I;
                        is_write          <= grant_d && d_we;
                        line_q            <= sel_line;
                        mem.mem_addr      <= {sel_line, {BEAT_W{1'b0}}, 2'b00};
                        mem.mem_wdata     <= d_wdata;
                        mem.mem_read_req  <= !(grant_d && d_we);
                        mem.mem_write_req <= grant_d && d_we;
`ifdef MEM_SEQ_TIMEOUT_EN
                        wdog              <= '0;
`endif
                        state             <= S_REQ;
                    end
                end

                S_REQ: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (mem.mem_res) begin
                        mem.mem_read_req  <= 1'b0;
                        mem.mem_write_req <= 1'b0;
                        if (!is_write) begin
                            rdata <= mem.mem_rdata;
                            if (side == SIDE_D) d_rvalid <= 1'b1;
                            else                i_rvalid <= 1'b1;
                        end
                        if (beat == LAST_BEAT) begin
                            if (side == SIDE_D) d_done <= 1'b1;
                            else                i_done <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            beat  <= beat + 1'b1;
                            state <= S_GAP;
                        end
                    end
`ifdef MEM_SEQ_TIMEOUT_EN
                    else if (wdog == 16'(TIMEOUT_CYCLES - 1)) begin
                        // Beat never answered: abort the line, done rides with err.
                        mem.mem_read_req  <= 1'b0;
                        mem.mem_write_req <= 1'b0;
                        err               <= 1'b1;
                        if (side == SIDE_D) d_done <= 1'b1;
                        else                i_done <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end

                S_GAP: begin
                    // beat already points at the next word, so d_wdata is for that beat.
                    mem.mem_addr      <= {line_q, beat, 2'b00};
                    mem.mem_wdata     <= d_wdata;
                    mem.mem_read_req  <= !is_write;
                    mem.mem_write_req <= is_write;
`ifdef MEM_SEQ_TIMEOUT_EN
                    wdog              <= '0;
`endif
                    state             <= S_REQ;
                end

                S_DONE: begin
                    last_grant <= side;
                    beat       <= '0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_sequencer.sv
// Directed bench for mem_line_sequencer: a small latency memory model answers
// each request rising edge; a negedge monitor logs beats, gaps, read words and
// done pulses; one linear initial block drives the scenarios and checks logs.
module tb_mem_line_sequencer;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int MEMLAT     = 3;
    localparam logic [31:0] RD_KEY = 32'hDEAD_0000;

    logic        mem_clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic        d_done;
    logic [31:0] rdata;
    logic [1:0]  beat;
    logic        err;

    logic        withhold;
    logic        inject;

    int tests = 0;
    int fails = 0;

    always #5 mem_clk = ~mem_clk;

    mem_line_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_line_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .TIMEOUT_CYCLES(8)
    ) dut (
        .mem_clk(mem_clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_done(d_done),
        .rdata(rdata), .beat(beat), .err(err), .mem(bus)
    );

    // Write client presents the word for the beat currently shown.
    always_comb d_wdata = 32'h0000_00A0 + 32'(beat);

    // Memory model: answers MEMLAT+1 cycles after a request rising edge.
    int   lat_cnt;
    logic prev_mreq;
    always @(posedge mem_clk) begin
        if (rst) begin
            lat_cnt       <= 0;
            prev_mreq     <= 1'b0;
            bus.mem_res   <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            prev_mreq   <= bus.mem_read_req | bus.mem_write_req;
            bus.mem_res <= inject;
            if ((bus.mem_read_req | bus.mem_write_req) && !prev_mreq && !withhold) begin
                lat_cnt <= MEMLAT;
            end else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1) begin
                    bus.mem_res   <= 1'b1;
                    bus.mem_rdata <= bus.mem_addr ^ RD_KEY;
                end
            end
        end
    end

    // Monitor: logs beat starts, inter-beat gaps, read words and done order.
    int          i_done_cnt = 0, d_done_cnt = 0, i_rv_cnt = 0, d_rv_cnt = 0, both_cnt = 0;
    int          low_run = 0;
    bit          in_line = 1'b0, prev_req = 1'b0, req_now;
    logic [31:0] addr_q[$];
    logic [31:0] wdata_q[$];
    logic [31:0] rdata_q[$];
    bit          we_q[$];
    int          gap_q[$];
    bit          done_q[$];
    always @(negedge mem_clk) begin
        req_now = bus.mem_read_req | bus.mem_write_req;
        if (rst) begin
            prev_req = 1'b0;
            in_line  = 1'b0;
            low_run  = 0;
        end else begin
            if (bus.mem_read_req && bus.mem_write_req) both_cnt++;
            if (!req_now) begin
                low_run++;
            end else if (!prev_req) begin
                if (in_line) gap_q.push_back(low_run);
                low_run = 0;
                in_line = 1'b1;
                addr_q.push_back(bus.mem_addr);
                wdata_q.push_back(bus.mem_wdata);
                we_q.push_back(bus.mem_write_req);
            end
            if (i_rvalid) begin i_rv_cnt++; rdata_q.push_back(rdata); end
            if (d_rvalid) begin d_rv_cnt++; rdata_q.push_back(rdata); end
            if (i_done)   begin i_done_cnt++; done_q.push_back(1'b0); in_line = 1'b0; end
            if (d_done)   begin d_done_cnt++; done_q.push_back(1'b1); in_line = 1'b0; end
            prev_req = req_now;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to just after the falling edge so the monitor has already run.
    task automatic tick();
        @(negedge mem_clk);
        #1;
    endtask

    task automatic wait_dones(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            tick();
            if (i_done_cnt + d_done_cnt >= target) ok = 1'b1;
        end
    endtask

    function automatic logic [63:0] all_ctl();
        return {56'(0), i_rvalid, i_done, d_rvalid, d_done, err, beat,
                bus.mem_read_req | bus.mem_write_req};
    endfunction

    int          ab, rb, gb, db, irv0, drv0, id0, dd0;
    bit          ok;
    logic [31:0] exp_a;

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
        withhold = 1'b0; inject = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_ctl", all_ctl(), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        tick();

        // 1: I-side line read
        ab = addr_q.size(); rb = rdata_q.size(); gb = gap_q.size();
        irv0 = i_rv_cnt; drv0 = d_rv_cnt; id0 = i_done_cnt; dd0 = d_done_cnt;
        i_req = 1'b1; i_addr = 32'h0001_0040;
        wait_dones(i_done_cnt + d_done_cnt + 1, ok);
        i_req = 1'b0;
        check("t1_finished", 64'(ok), 64'd1);
        check("t1_idone", 64'(i_done_cnt - id0), 64'd1);
        check("t1_ddone", 64'(d_done_cnt - dd0), 64'd0);
        check("t1_nbeats", 64'(addr_q.size() - ab), 64'd4);
        check("t1_irvalid", 64'(i_rv_cnt - irv0), 64'd4);
        check("t1_drvalid", 64'(d_rv_cnt - drv0), 64'd0);
        for (int k = 0; k < 4; k++) begin
            exp_a = 32'h0001_0040 + 32'(4 * k);
            check($sformatf("t1_addr%0d", k), 64'(addr_q[ab + k]), 64'(exp_a));
            check($sformatf("t1_we%0d", k), 64'(we_q[ab + k]), 64'd0);
            check($sformatf("t1_rdata%0d", k), 64'(rdata_q[rb + k]), 64'(exp_a ^ RD_KEY));
        end
        check("t1_ngaps", 64'(gap_q.size() - gb), 64'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("t1_gap%0d", k), 64'(gap_q[gb + k]), 64'd1);
        tick();
        check("t1_idle", all_ctl(), 64'd0);

        // 2: D-side line writeback
        ab = addr_q.size(); gb = gap_q.size();
        irv0 = i_rv_cnt; drv0 = d_rv_cnt; id0 = i_done_cnt; dd0 = d_done_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100;
        wait_dones(i_done_cnt + d_done_cnt + 1, ok);
        d_req = 1'b0; d_we = 1'b0;
        check("t2_finished", 64'(ok), 64'd1);
        check("t2_ddone", 64'(d_done_cnt - dd0), 64'd1);
        check("t2_idone", 64'(i_done_cnt - id0), 64'd0);
        check("t2_drvalid", 64'(d_rv_cnt - drv0), 64'd0);
        check("t2_irvalid", 64'(i_rv_cnt - irv0), 64'd0);
        check("t2_nbeats", 64'(addr_q.size() - ab), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_addr%0d", k), 64'(addr_q[ab + k]), 64'(32'h100 + 32'(4 * k)));
            check($sformatf("t2_wdata%0d", k), 64'(wdata_q[ab + k]), 64'(32'hA0 + 32'(k)));
            check($sformatf("t2_we%0d", k), 64'(we_q[ab + k]), 64'd1);
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("t2_gap%0d", k), 64'(gap_q[gb + k]), 64'd1);
        tick();

        // 3: simultaneous requests after reset -> D, I, D
        rst = 1'b1; tick(); rst = 1'b0; tick();
        ab = addr_q.size(); db = done_q.size();
        d_addr = 32'h0000_0200; i_addr = 32'h0000_0300;
        i_req = 1'b1; d_req = 1'b1;
        wait_dones(i_done_cnt + d_done_cnt + 3, ok);
        i_req = 1'b0; d_req = 1'b0;
        check("t3_finished", 64'(ok), 64'd1);
        check("t3_first_addr", 64'(addr_q[ab]), 64'h200);
        check("t3_order0", 64'(done_q[db]), 64'd1);
        check("t3_order1", 64'(done_q[db + 1]), 64'd0);
        check("t3_order2", 64'(done_q[db + 2]), 64'd1);
        check("t3_second_addr", 64'(addr_q[ab + 4]), 64'h300);
        repeat (3) tick();

        // 4: read and write request never overlapped so far
        check("t4_rw_overlap", 64'(both_cnt), 64'd0);

        // 5: reset in the middle of a line
        i_req = 1'b1; i_addr = 32'h0000_0400;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            tick();
            if (beat == 2'd2 && bus.mem_read_req) ok = 1'b1;
        end
        check("t5_reached_beat2", 64'(ok), 64'd1);
        rst = 1'b1; i_req = 1'b0;
        tick();
        check("t5_rst_ctl", all_ctl(), 64'd0);
        check("t5_rst_addr", 64'(bus.mem_addr), 64'd0);
        check("t5_rst_rdata", 64'(rdata), 64'd0);
        id0 = i_done_cnt; irv0 = i_rv_cnt;
        rst = 1'b0; inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (5) tick();
        check("t5_no_done", 64'(i_done_cnt - id0), 64'd0);
        check("t5_no_rvalid", 64'(i_rv_cnt - irv0), 64'd0);
        check("t5_idle", all_ctl(), 64'd0);

`ifdef MEM_SEQ_TIMEOUT_EN
        // 6: response withheld -> watchdog abort
        withhold = 1'b1; i_req = 1'b1; i_addr = 32'h0000_0500;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            tick();
            if (bus.mem_read_req) ok = 1'b1;
        end
        check("t6_req_seen", 64'(ok), 64'd1);
        begin
            int n_cyc;
            n_cyc = 0; ok = 1'b0;
            while (n_cyc < 100 && !ok) begin
                tick();
                n_cyc++;
                if (err) ok = 1'b1;
            end
            i_req = 1'b0;
            check("t6_err", 64'(ok), 64'd1);
            check("t6_err_latency", 64'(n_cyc), 64'd9);
            check("t6_done_with_err", 64'(i_done), 64'd1);
            check("t6_req_dropped", 64'(bus.mem_read_req), 64'd0);
        end
        tick();
        check("t6_idle", all_ctl(), 64'd0);
        withhold = 1'b0;
`else
        check("err_tied", 64'(err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
